// File: rtl/xpar_bridge.sv
// Bridge from a single-request controller bus to an external parallel port with
// read/write strobes; terminates on a fixed cycle count or on an acknowledge with timeout.
module xpar_bridge #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2,
    parameter int USE_ACK  = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] par_addr,
    output logic [DATA_W-1:0] par_out,
    input  logic [DATA_W-1:0] par_in,
    output logic              par_re,
    output logic              par_we,
    input  logic              par_ack
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [7:0] LAST_FIX = 8'(WAIT_CYC);
    localparam logic [7:0] LAST_TO  = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   par_addr_q, par_addr_d;
    logic [DATA_W-1:0]   par_out_q, par_out_d;
    logic                par_re_q, par_re_d;
    logic                par_we_q, par_we_d;
    logic                done_ev, err_ev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            par_addr_q <= '0;
            par_out_q  <= '0;
            par_re_q   <= 1'b0;
            par_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            par_addr_q <= par_addr_d;
            par_out_q  <= par_out_d;
            par_re_q   <= par_re_d;
            par_we_q   <= par_we_d;
        end
    end

    // cnt_q counts completed strobe cycles, so cnt_q == N means this is cycle N+1.
    always_comb begin
        state_d = state_q;
        done_ev = 1'b0;
        err_ev  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel) state_d = S_STROBE;
            end
            S_STROBE: begin
                if (USE_ACK == 0) begin
                    done_ev = (cnt_q == LAST_FIX);
                end else begin
                    done_ev = par_ack;
                    err_ev  = !par_ack && (cnt_q == LAST_TO);
                end
                if (done_ev)     state_d = S_DONE;
                else if (err_ev) state_d = S_ERR;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Completion outputs are registered on the edge leaving STROBE so they line up with DONE/ERR.
    always_comb begin
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        par_addr_d = par_addr_q;
        par_out_d  = par_out_q;
        par_re_d   = par_re_q;
        par_we_d   = par_we_q;
        case (state_q)
            S_IDLE: begin
                if (sel) begin
                    cnt_d      = '0;
                    par_addr_d = addr;
                    par_out_d  = data_in;
                    par_re_d   = !we;
                    par_we_d   = we;
                end
            end
            S_STROBE: begin
                cnt_d = cnt_q + 8'd1;
                if (done_ev) begin
                    par_re_d = 1'b0;
                    par_we_d = 1'b0;
                    ready_d  = 1'b1;
                    if (par_re_q) data_out_d = par_in;
                end else if (err_ev) begin
                    par_re_d   = 1'b0;
                    par_we_d   = 1'b0;
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    data_out_d = '0;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign data_out = data_out_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign par_addr = par_addr_q;
    assign par_out  = par_out_q;
    assign par_re   = par_re_q;
    assign par_we   = par_we_q;

endmodule

// File: tb/tb_xpar_bridge.sv
// Bench for xpar_bridge: four instances covering fixed timing (WAIT_CYC 2 and 0),
// acknowledge mode with a short timeout, and acknowledge mode with the default timeout.
module tb_xpar_bridge;

    logic        clk;
    logic        rst;
    logic [3:0]  sel;
    logic        we;
    logic [10:0] addr;
    logic [31:0] data_in;
    logic [31:0] par_in;
    logic        par_ack;

    logic [31:0] dout  [4];
    logic        rdy   [4];
    logic        errs  [4];
    logic [7:0]  ecnt  [4];
    logic [10:0] paddr [4];
    logic [31:0] pout  [4];
    logic        pre   [4];
    logic        pwe   [4];

    int checks;
    int failures;

    // Reference model: per-instance timing parameters and expected registered state.
    int          wait_p    [4] = '{2, 0, 2, 2};
    int          use_ack_p [4] = '{0, 0, 1, 1};
    int          to_p      [4] = '{15, 15, 4, 15};
    logic [31:0] exp_data  [4];
    int          exp_cnt   [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    xpar_bridge #(.WAIT_CYC(2), .USE_ACK(0), .TIMEOUT(15)) u_fix2 (
        .clk(clk), .rst(rst), .sel(sel[0]), .we(we), .addr(addr), .data_in(data_in),
        .data_out(dout[0]), .ready(rdy[0]), .err(errs[0]), .err_cnt(ecnt[0]),
        .par_addr(paddr[0]), .par_out(pout[0]), .par_in(par_in),
        .par_re(pre[0]), .par_we(pwe[0]), .par_ack(par_ack)
    );
    xpar_bridge #(.WAIT_CYC(0), .USE_ACK(0), .TIMEOUT(15)) u_fix0 (
        .clk(clk), .rst(rst), .sel(sel[1]), .we(we), .addr(addr), .data_in(data_in),
        .data_out(dout[1]), .ready(rdy[1]), .err(errs[1]), .err_cnt(ecnt[1]),
        .par_addr(paddr[1]), .par_out(pout[1]), .par_in(par_in),
        .par_re(pre[1]), .par_we(pwe[1]), .par_ack(par_ack)
    );
    xpar_bridge #(.WAIT_CYC(2), .USE_ACK(1), .TIMEOUT(4)) u_ack4 (
        .clk(clk), .rst(rst), .sel(sel[2]), .we(we), .addr(addr), .data_in(data_in),
        .data_out(dout[2]), .ready(rdy[2]), .err(errs[2]), .err_cnt(ecnt[2]),
        .par_addr(paddr[2]), .par_out(pout[2]), .par_in(par_in),
        .par_re(pre[2]), .par_we(pwe[2]), .par_ack(par_ack)
    );
    xpar_bridge #(.WAIT_CYC(2), .USE_ACK(1), .TIMEOUT(15)) u_ack15 (
        .clk(clk), .rst(rst), .sel(sel[3]), .we(we), .addr(addr), .data_in(data_in),
        .data_out(dout[3]), .ready(rdy[3]), .err(errs[3]), .err_cnt(ecnt[3]),
        .par_addr(paddr[3]), .par_out(pout[3]), .par_in(par_in),
        .par_re(pre[3]), .par_we(pwe[3]), .par_ack(par_ack)
    );

    // One complete access on instance k, entered and left at a falling edge.
    // ack_at: strobe cycle (1-based) from which par_ack is held high; 0 = never.
    task automatic access(input int k, input logic w, input logic [10:0] a,
                          input logic [31:0] d, input logic [31:0] pin, input int ack_at);
        int   n;
        int   exp_len;
        logic exp_e;
        if (use_ack_p[k] == 0) begin
            exp_len = wait_p[k] + 1;
            exp_e   = 1'b0;
        end else if (ack_at >= 1 && ack_at <= to_p[k]) begin
            exp_len = ack_at;
            exp_e   = 1'b0;
        end else begin
            exp_len = to_p[k];
            exp_e   = 1'b1;
        end
        we = w; addr = a; data_in = d; par_in = pin; par_ack = 1'b0; sel[k] = 1'b1;
        @(negedge clk);
        sel[k] = 1'b0; we = 1'($urandom); addr = 11'($urandom); data_in = $urandom;
        n = 0;
        while ((pre[k] || pwe[k]) && n < 300) begin
            n++;
            checks++;
            if (paddr[k] !== a || pout[k] !== d || pre[k] !== !w || pwe[k] !== w || rdy[k] !== 1'b0) begin
                failures++;
                $display("FAIL strobe inst=%0d cyc=%0d got addr=%h out=%h re=%b we=%b rdy=%b want addr=%h out=%h re=%b we=%b rdy=0",
                         k, n, paddr[k], pout[k], pre[k], pwe[k], rdy[k], a, d, !w, w);
            end
            sel[k] = 1'($urandom);
            if (use_ack_p[k] != 0) par_ack = (ack_at != 0 && n >= ack_at);
            else                   par_ack = 1'($urandom);
            @(negedge clk);
        end
        sel[k] = 1'b0; par_ack = 1'b0;
        checks++;
        if (n !== exp_len) begin
            failures++;
            $display("FAIL strobe_len inst=%0d got %0d want %0d", k, n, exp_len);
        end
        if (exp_e) begin
            exp_data[k] = 32'h0;
            if (exp_cnt[k] < 255) exp_cnt[k]++;
        end else if (!w) begin
            exp_data[k] = pin;
        end
        checks++;
        if (rdy[k] !== 1'b1 || errs[k] !== exp_e || dout[k] !== exp_data[k] || ecnt[k] !== 8'(exp_cnt[k])) begin
            failures++;
            $display("FAIL complete inst=%0d got rdy=%b err=%b dout=%h cnt=%0d want rdy=1 err=%b dout=%h cnt=%0d",
                     k, rdy[k], errs[k], dout[k], ecnt[k], exp_e, exp_data[k], exp_cnt[k]);
        end
        par_in = $urandom;
        @(negedge clk);
        checks++;
        if (rdy[k] !== 1'b0 || errs[k] !== 1'b0 || dout[k] !== exp_data[k] || pre[k] !== 1'b0 || pwe[k] !== 1'b0) begin
            failures++;
            $display("FAIL after_done inst=%0d got rdy=%b err=%b dout=%h re=%b we=%b want rdy=0 err=0 dout=%h re=0 we=0",
                     k, rdy[k], errs[k], dout[k], pre[k], pwe[k], exp_data[k]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dout[k] !== 32'h0 || rdy[k] !== 1'b0 || errs[k] !== 1'b0 || ecnt[k] !== 8'h0 ||
                paddr[k] !== 11'h0 || pout[k] !== 32'h0 || pre[k] !== 1'b0 || pwe[k] !== 1'b0) begin
                failures++;
                $display("FAIL %s inst=%0d got dout=%h rdy=%b err=%b cnt=%0d addr=%h out=%h re=%b we=%b want all zero",
                         tag, k, dout[k], rdy[k], errs[k], ecnt[k], paddr[k], pout[k], pre[k], pwe[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; sel = '0; we = 1'b0; addr = '0; data_in = '0; par_in = '0; par_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_data[k] = 32'h0;
            exp_cnt[k]  = 0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fixed_read();
        access(0, 1'b0, 11'h155, $urandom, 32'hDEADBEEF, 0);
    endtask

    task automatic test_fixed_write();
        access(1, 1'b0, 11'h010, $urandom, 32'hCAFEF00D, 0);
        access(1, 1'b1, 11'h7FF, 32'h12345678, $urandom, 0);
    endtask

    task automatic test_ack_read();
        access(3, 1'b0, 11'($urandom), $urandom, 32'hA5A5A5A5, 5);
        access(2, 1'b0, 11'($urandom), $urandom, 32'h0BADCAFE, 4);
    endtask

    task automatic test_timeout();
        access(2, 1'b0, 11'($urandom), $urandom, $urandom, 0);
        for (int i = 0; i < 299; i++)
            access(2, 1'($urandom), 11'($urandom), $urandom, $urandom, 0);
        checks++;
        if (ecnt[2] !== 8'd255) begin
            failures++;
            $display("FAIL err_cnt_sat got %0d want 255", ecnt[2]);
        end
    endtask

    task automatic test_reset_mid_access();
        we = 1'b1; addr = 11'h2AA; data_in = 32'h55AA55AA; sel[0] = 1'b1;
        @(negedge clk);
        sel[0] = 1'b0;
        checks++;
        if (pwe[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_pre got par_we=%b want 1", pwe[0]);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_data[k] = 32'h0;
            exp_cnt[k]  = 0;
        end
        check_all_zero("mid_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rdy[0] !== 1'b0 || pwe[0] !== 1'b0) begin
                failures++;
                $display("FAIL mid_rst_hold cyc=%0d got rdy=%b par_we=%b want 0 0", i, rdy[0], pwe[0]);
            end
        end
        rst = 1'b1;
        access(0, 1'b0, 11'h123, $urandom, 32'h600DF00D, 0);
    endtask

    task automatic test_back_to_back();
        access(0, 1'b0, 11'h001, $urandom, 32'h11111111, 0);
        access(0, 1'b0, 11'h002, $urandom, 32'h22222222, 0);
        access(1, 1'b0, 11'h003, $urandom, 32'h33333333, 0);
        access(1, 1'b1, 11'h004, 32'h44444444, $urandom, 0);
        access(1, 1'b0, 11'h005, $urandom, 32'h55555555, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 3);
            access(k, 1'($urandom), 11'($urandom), $urandom, $urandom,
                   $urandom_range(0, to_p[k] + 2));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_fixed_read();
        test_fixed_write();
        test_ack_read();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
